path_query_sequencer: RTL

- Sequences the day-11 path-count engine for part 2: counts `svr`→`out` paths that pass through both `dac` and `fft`.
- Issues six (src, dst) path-count queries to one shared count engine, one query at a time.
- Combines the results as total = P(svr,dac)·P(dac,fft)·P(fft,out) + P(svr,fft)·P(fft,dac)·P(dac,out).
- Sits between the top-level start/done handshake and the topo-order path-count datapath.

---
 rtl/day11_pkg.sv | 37 +++
 rtl/path_leg_mac.sv | 27 ++
 rtl/path_query_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/day11_pkg.sv
// Shared day-11 definitions: node IDs, sequencer state encoding and the part-2 query table.
package day11_pkg;

  localparam logic [15:0] SVR_ID = 16'h0000;
  localparam logic [15:0] DAC_ID = 16'h0001;
  localparam logic [15:0] FFT_ID = 16'h0002;
  localparam logic [15:0] OUT_ID = 16'h0003;
  localparam logic [15:0] YOU_ID = 16'h0004;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_ACCUM = 3'd3;
  localparam state_t ST_FIN   = 3'd4;

  localparam int          NUM_QUERIES  = 6;
  localparam logic [2:0]  CHAIN_B_QIDX = 3'd3;
  localparam logic [2:0]  LAST_QIDX    = 3'd5;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic        chain_end;
  } query_t;

  // Chain A: svr->dac->fft->out, chain B: svr->fft->dac->out
  localparam query_t QUERY_TABLE [NUM_QUERIES] = '{
    '{src: SVR_ID, dst: DAC_ID, chain_end: 1'b0},
    '{src: DAC_ID, dst: FFT_ID, chain_end: 1'b0},
    '{src: FFT_ID, dst: OUT_ID, chain_end: 1'b1},
    '{src: SVR_ID, dst: FFT_ID, chain_end: 1'b0},
    '{src: FFT_ID, dst: DAC_ID, chain_end: 1'b0},
    '{src: DAC_ID, dst: OUT_ID, chain_end: 1'b1}
  };

endpackage

// File: rtl/path_leg_mac.sv
// Combinational leg arithmetic: truncated prod*count with overflow flag, and chain accumulate with carry.
module path_leg_mac #(
  parameter int CNT_W = 64
) (
  input  logic [CNT_W-1:0] prod_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [CNT_W-1:0] acc_i,
  output logic [CNT_W-1:0] prod_o,
  output logic             prod_ovf_o,
  output logic [CNT_W-1:0] acc_o,
  output logic             acc_carry_o
);

  logic [2*CNT_W-1:0] full_prod;
  logic [CNT_W:0]     full_sum;

  always_comb begin
    full_prod = {{CNT_W{1'b0}}, prod_i} * {{CNT_W{1'b0}}, count_i};
    full_sum  = {1'b0, acc_i} + {1'b0, prod_i};
  end

  assign prod_o      = full_prod[CNT_W-1:0];
  assign prod_ovf_o  = |full_prod[2*CNT_W-1:CNT_W];
  assign acc_o       = full_sum[CNT_W-1:0];
  assign acc_carry_o = full_sum[CNT_W];

endmodule

// File: rtl/path_query_sequencer.sv
// Part-2 sequencer: issues six path-count queries and sums the two chain products.
// Build macro PQS_SKIP_ZERO_EN: stop issuing a chain's remaining legs once a leg returns zero.
module path_query_sequencer
  import day11_pkg::*;
#(
  parameter int                NODE_W   = 16,
  parameter int                CNT_W    = 64,
  parameter logic [NODE_W-1:0] SVR_NODE = NODE_W'(SVR_ID),
  parameter logic [NODE_W-1:0] DAC_NODE = NODE_W'(DAC_ID),
  parameter logic [NODE_W-1:0] FFT_NODE = NODE_W'(FFT_ID),
  parameter logic [NODE_W-1:0] OUT_NODE = NODE_W'(OUT_ID)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  total_paths,
  output logic              overflow,
  output logic              eng_start,
  output logic [NODE_W-1:0] eng_src,
  output logic [NODE_W-1:0] eng_dst,
  input  logic              eng_done,
  input  logic [CNT_W-1:0]  eng_count
);

  state_t            state_q, state_d;
  logic [2:0]        qidx_q, qidx_d;
  logic [CNT_W-1:0]  prod_q, prod_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              eng_start_q, eng_start_d;
  logic [NODE_W-1:0] src_q, src_d;
  logic [NODE_W-1:0] dst_q, dst_d;
`ifdef PQS_SKIP_ZERO_EN
  logic              leg_zero_q, leg_zero_d;
`endif

  logic              issue_now;
  logic [2:0]        issue_idx;
  logic              skip;
  logic [CNT_W-1:0]  mul_res, sum_res;
  logic              mul_ovf, sum_carry;

  // Table holds canonical IDs; remap so overridden node parameters take effect.
  function automatic logic [NODE_W-1:0] map_node(input logic [15:0] id);
    case (id)
      DAC_ID:  return DAC_NODE;
      FFT_ID:  return FFT_NODE;
      OUT_ID:  return OUT_NODE;
      default: return SVR_NODE;
    endcase
  endfunction

  path_leg_mac #(.CNT_W(CNT_W)) u_mac (
    .prod_i      (prod_q),
    .count_i     (eng_count),
    .acc_i       (acc_q),
    .prod_o      (mul_res),
    .prod_ovf_o  (mul_ovf),
    .acc_o       (sum_res),
    .acc_carry_o (sum_carry)
  );

  always_comb begin
    state_d     = state_q;
    qidx_d      = qidx_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    total_d     = total_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    eng_start_d = 1'b0;
    src_d       = src_q;
    dst_d       = dst_q;
    issue_now   = 1'b0;
    issue_idx   = qidx_q;
`ifdef PQS_SKIP_ZERO_EN
    leg_zero_d  = leg_zero_q;
    skip        = leg_zero_q && !QUERY_TABLE[qidx_q].chain_end;
`else
    skip        = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          qidx_d    = 3'd0;
          prod_d    = CNT_W'(1);
          acc_d     = '0;
          ovf_d     = 1'b0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          issue_now = 1'b1;
          issue_idx = 3'd0;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          prod_d = mul_res;
          if (mul_ovf) ovf_d = 1'b1;
`ifdef PQS_SKIP_ZERO_EN
          leg_zero_d = (eng_count == '0);
`endif
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (QUERY_TABLE[qidx_q].chain_end) begin
          acc_d  = sum_res;
          prod_d = CNT_W'(1);
          if (sum_carry) ovf_d = 1'b1;
        end else if (skip) begin
          prod_d = CNT_W'(1);
        end
        // A skipped chain contributes nothing, so acc is left untouched.
        if (qidx_q == LAST_QIDX || (skip && qidx_q >= CHAIN_B_QIDX)) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          total_d = acc_d;
        end else begin
          issue_now = 1'b1;
          issue_idx = skip ? CHAIN_B_QIDX : qidx_q + 3'd1;
          qidx_d    = issue_idx;
          state_d   = ST_ISSUE;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (issue_now) begin
      eng_start_d = 1'b1;
      src_d       = map_node(QUERY_TABLE[issue_idx].src);
      dst_d       = map_node(QUERY_TABLE[issue_idx].dst);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      qidx_q      <= 3'd0;
      prod_q      <= CNT_W'(1);
      acc_q       <= '0;
      total_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      eng_start_q <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
`ifdef PQS_SKIP_ZERO_EN
      leg_zero_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      qidx_q      <= qidx_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      total_q     <= total_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      eng_start_q <= eng_start_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
`ifdef PQS_SKIP_ZERO_EN
      leg_zero_q  <= leg_zero_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign total_paths = total_q;
  assign overflow    = ovf_q;
  assign eng_start   = eng_start_q;
  assign eng_src     = src_q;
  assign eng_dst     = dst_q;

endmodule
